// File: rtl/switch_cfg_loader.sv
// switch_cfg_loader
//   Receives a framed configuration byte stream (HEADER, 18 entry bytes,
//   checksum), validates every entry and the XOR checksum, and only then
//   commits the whole switch-matrix configuration to cfg_out in one edge.
//
// Ports
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   cfg_valid  - cfg_data holds a byte (transfer on cfg_valid && cfg_ready)
//   cfg_data   - configuration byte stream
//   cfg_ready  - loader accepts a byte this cycle
//   cfg_abort  - synchronous request to discard the current frame
//   cfg_out    - active config, entry k at bits [6k+5:6k]
//   cfg_done   - one-cycle pulse on a successful commit
//   cfg_err    - one-cycle pulse on a rejected frame
//   err_code   - last rejection reason: 00 none, 01 checksum, 10 illegal entry
//   busy       - high whenever the loader is not idle
module switch_cfg_loader #(
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_valid,
    input  logic [7:0]   cfg_data,
    output logic         cfg_ready,
    input  logic         cfg_abort,
    output logic [107:0] cfg_out,
    output logic         cfg_done,
    output logic         cfg_err,
    output logic [1:0]   err_code,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHK,
        COMMIT,
        ERR
    } state_t;

    state_t     state;
    logic [5:0] shadow [18];
    logic [4:0] count;
    logic [5:0] xsum;
    logic       illegal;
    logic [1:0] pend_code;
    logic       take;
    logic       byte_bad;

    assign take = cfg_valid && cfg_ready;

    // Entry legality: sel 0 is high-Z (any index); top/bottom have 5 pins,
    // left/right have 4; sel 5..7 and nonzero bits [7:6] are never legal.
    always_comb begin
        byte_bad = 1'b0;
        if (cfg_data[7:6] != 2'b00) begin
            byte_bad = 1'b1;
        end else begin
            case (cfg_data[2:0])
                3'd0:       byte_bad = 1'b0;
                3'd1, 3'd3: byte_bad = (cfg_data[5:3] > 3'd4);
                3'd2, 3'd4: byte_bad = (cfg_data[5:3] > 3'd3);
                default:    byte_bad = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            cfg_out   <= '0;
            count     <= '0;
            xsum      <= '0;
            illegal   <= 1'b0;
            pend_code <= 2'b00;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            err_code  <= 2'b00;
            for (int unsigned k = 0; k < 18; k++) shadow[k] <= '0;
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            // Abort outranks everything, including a byte offered this cycle
            // and the COMMIT/ERR updates.
            if (cfg_abort) begin
                state     <= IDLE;
                cfg_ready <= 1'b1;
                busy      <= 1'b0;
                count     <= '0;
                xsum      <= '0;
                illegal   <= 1'b0;
                for (int unsigned k = 0; k < 18; k++) shadow[k] <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (take && cfg_data == HEADER) begin
                            state   <= LOAD;
                            busy    <= 1'b1;
                            count   <= '0;
                            xsum    <= '0;
                            illegal <= 1'b0;
                        end
                    end
                    LOAD: begin
                        if (take) begin
                            shadow[count] <= cfg_data[5:0];
                            xsum          <= xsum ^ cfg_data[5:0];
                            illegal       <= illegal | byte_bad;
                            count         <= count + 5'd1;
                            if (count == 5'd17) state <= CHK;
                        end
                    end
                    CHK: begin
                        if (take) begin
                            cfg_ready <= 1'b0;
                            if (illegal) begin
                                state     <= ERR;
                                pend_code <= 2'b10;
                            end else if (cfg_data != {2'b00, xsum}) begin
                                state     <= ERR;
                                pend_code <= 2'b01;
                            end else begin
                                state <= COMMIT;
                            end
                        end
                    end
                    COMMIT: begin
                        for (int unsigned k = 0; k < 18; k++) cfg_out[6*k +: 6] <= shadow[k];
                        cfg_done  <= 1'b1;
                        err_code  <= 2'b00;
                        state     <= IDLE;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                    ERR: begin
                        cfg_err   <= 1'b1;
                        err_code  <= pend_code;
                        state     <= IDLE;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                    default: begin
                        state     <= IDLE;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_switch_cfg_loader.sv
module tb_switch_cfg_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_valid;
    logic [7:0]   cfg_data;
    logic         cfg_ready;
    logic         cfg_abort;
    logic [107:0] cfg_out;
    logic         cfg_done;
    logic         cfg_err;
    logic [1:0]   err_code;
    logic         busy;

    switch_cfg_loader #(.HEADER(8'hA5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_valid(cfg_valid),
        .cfg_data (cfg_data),
        .cfg_ready(cfg_ready),
        .cfg_abort(cfg_abort),
        .cfg_out  (cfg_out),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err),
        .err_code (err_code),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference state: what the active configuration and error code must be.
    logic [107:0] exp_out;
    logic [1:0]   exp_code;

    int acc_cyc, hdr_cyc;
    int n_ready_low, n_done, n_err, pulse_at;

    // Pins available on the side named by sel; sel 0 (high-Z) takes any index.
    function automatic bit entry_legal(input logic [7:0] b);
        int pins;
        if (b[7:6] != 2'b00) return 1'b0;
        case (b[2:0])
            3'd0:       pins = 8;
            3'd1, 3'd3: pins = 5;
            3'd2, 3'd4: pins = 4;
            default:    return 1'b0;
        endcase
        return int'(b[5:3]) < pins;
    endfunction

    // Outcome of a whole frame: 00 commit, 01 bad checksum, 10 illegal entry.
    function automatic logic [1:0] predict(input logic [7:0] ent [18], input logic [7:0] chk);
        logic [5:0] x;
        bit bad;
        x = '0;
        bad = 1'b0;
        for (int k = 0; k < 18; k++) begin
            if (!entry_legal(ent[k])) bad = 1'b1;
            x = x ^ ent[k][5:0];
        end
        if (bad) return 2'b10;
        if (chk != {2'b00, x}) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [7:0] xor_of(input logic [7:0] ent [18]);
        logic [5:0] x;
        x = '0;
        for (int k = 0; k < 18; k++) x = x ^ ent[k][5:0];
        return {2'b00, x};
    endfunction

    function automatic logic [7:0] rand_legal();
        logic [2:0] sel;
        logic [2:0] idx;
        sel = 3'($urandom_range(4, 0));
        case (sel)
            3'd0:       idx = 3'($urandom_range(7, 0));
            3'd1, 3'd3: idx = 3'($urandom_range(4, 0));
            default:    idx = 3'($urandom_range(3, 0));
        endcase
        return {2'b00, idx, sel};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_data  = b;
        while (!cfg_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!cfg_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout cfg_ready=%0b required 1", cfg_ready);
        end
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        cfg_valid = 1'b0;
        cfg_data  = 8'($urandom);
    endtask

    task automatic send_frame(input logic [7:0] ent [18], input logic [7:0] chk,
                              input int max_gap, input int stall9);
        send_byte(8'hA5);
        hdr_cyc = acc_cyc;
        for (int k = 0; k < 18; k++) begin
            repeat ((k == 9 && stall9 > 0) ? stall9 : int'($urandom_range(max_gap, 0))) @(negedge clk);
            send_byte(ent[k]);
        end
        send_byte(chk);
    endtask

    task automatic observe();
        n_ready_low = 0;
        n_done = 0;
        n_err = 0;
        pulse_at = 0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (!cfg_ready) n_ready_low++;
            if (cfg_done) begin n_done++; pulse_at = i; end
            if (cfg_err)  begin n_err++;  pulse_at = i; end
        end
    endtask

    // Sends one frame, then compares pulses, timing and resulting state.
    task automatic test_frame(input string name, input logic [7:0] ent [18],
                              input logic [7:0] chk, input int max_gap, input int stall9);
        logic [1:0] code;
        code = predict(ent, chk);
        send_frame(ent, chk, max_gap, stall9);
        observe();
        if (code == 2'b00)
            for (int k = 0; k < 18; k++) exp_out[6*k +: 6] = ent[k][5:0];
        exp_code = code;
        checks++;
        if (n_done !== int'(code == 2'b00)) begin errors++; $display("FAIL %s done_pulses got %0d want %0d", name, n_done, int'(code == 2'b00)); end
        checks++;
        if (n_err !== int'(code != 2'b00)) begin errors++; $display("FAIL %s err_pulses got %0d want %0d", name, n_err, int'(code != 2'b00)); end
        checks++;
        if (pulse_at !== 2) begin errors++; $display("FAIL %s pulse_cycle got %0d want 2", name, pulse_at); end
        checks++;
        if (n_ready_low !== 1) begin errors++; $display("FAIL %s ready_low_cycles got %0d want 1", name, n_ready_low); end
        checks++;
        if (cfg_out !== exp_out) begin errors++; $display("FAIL %s cfg_out got %h want %h", name, cfg_out, exp_out); end
        checks++;
        if (err_code !== exp_code) begin errors++; $display("FAIL %s err_code got %b want %b", name, err_code, exp_code); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_after got %b want 0", name, busy); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        exp_out = '0;
        exp_code = 2'b00;
        checks++;
        if (cfg_out !== 108'h0 || cfg_done !== 1'b0 || cfg_err !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got out=%h done=%b err=%b want 0/0/0", cfg_out, cfg_done, cfg_err);
        end
        checks++;
        if (err_code !== 2'b00 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_status got code=%b busy=%b want 00/0", err_code, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cfg_ready); end
    endtask

    task automatic test_directed();
        logic [7:0] ent [18];
        for (int k = 0; k < 18; k++) ent[k] = 8'h00;
        test_frame("all_zero", ent, 8'h00, 0, 0);
        ent[0] = 8'h0A;
        ent[14] = 8'h1C;
        test_frame("two_entries", ent, 8'h16, 0, 0);
        checks++;
        if (cfg_out !== ((108'h1C << 84) | 108'h0A)) begin
            errors++; $display("FAIL two_entries_const got %h want 1C at 84, 0A at 0", cfg_out);
        end
        test_frame("bad_checksum", ent, 8'h17, 0, 0);
        for (int k = 0; k < 18; k++) ent[k] = 8'h00;
        ent[3] = 8'h22;
        test_frame("right_idx4", ent, 8'h22, 0, 0);
        ent[3] = 8'h2B;
        test_frame("bottom_idx5", ent, 8'h2B, 0, 0);
        ent[3] = 8'h40;
        test_frame("top_bits_set", ent, 8'h00, 0, 0);
        ent[3] = 8'hA5;
        test_frame("header_as_entry", ent, 8'h25, 0, 0);
    endtask

    task automatic test_idle_abort();
        logic [7:0] ent [18];
        send_byte(8'h00);
        send_byte(8'h13);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_drop busy got %b want 0", busy); end
        send_byte(8'hA5);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL header_start busy got %b want 1", busy); end
        for (int k = 0; k < 9; k++) send_byte(rand_legal());
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_data  = 8'hA5;
        cfg_abort = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        cfg_abort = 1'b0;
        observe();
        checks++;
        if (busy !== 1'b0 || n_done !== 0 || n_err !== 0) begin
            errors++; $display("FAIL abort_load got busy=%b done=%0d err=%0d want 0/0/0", busy, n_done, n_err);
        end
        checks++;
        if (cfg_out !== exp_out || err_code !== exp_code) begin
            errors++; $display("FAIL abort_keep got out=%h code=%b want %h/%b", cfg_out, err_code, exp_out, exp_code);
        end
        for (int k = 0; k < 18; k++) ent[k] = rand_legal();
        test_frame("after_abort", ent, xor_of(ent), 0, 0);
        // abort landing on COMMIT, then on ERR
        for (int k = 0; k < 18; k++) ent[k] = rand_legal();
        for (int pass = 0; pass < 2; pass++) begin
            send_frame(ent, xor_of(ent) ^ ((pass == 1) ? 8'h01 : 8'h00), 0, 0);
            cfg_abort = 1'b1;
            @(posedge clk);
            #1;
            cfg_abort = 1'b0;
            observe();
            checks++;
            if (n_done !== 0 || n_err !== 0 || busy !== 1'b0) begin
                errors++; $display("FAIL abort_final%0d got done=%0d err=%0d busy=%b want 0/0/0", pass, n_done, n_err, busy);
            end
            checks++;
            if (cfg_out !== exp_out || err_code !== exp_code) begin
                errors++; $display("FAIL abort_final%0d_keep got out=%h code=%b want %h/%b", pass, cfg_out, err_code, exp_out, exp_code);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] ent [18];
        send_byte(8'hA5);
        for (int k = 0; k < 10; k++) send_byte(rand_legal());
        #2;
        rst_n = 1'b0;
        #1;
        exp_out = '0;
        exp_code = 2'b00;
        checks++;
        if (cfg_out !== 108'h0 || busy !== 1'b0 || err_code !== 2'b00) begin
            errors++; $display("FAIL async_reset got out=%h busy=%b code=%b want 0/0/00", cfg_out, busy, err_code);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) send_byte(rand_legal());
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_needs_header busy got %b want 0", busy); end
        for (int k = 0; k < 18; k++) ent[k] = rand_legal();
        test_frame("stall5", ent, xor_of(ent), 0, 5);
    endtask

    task automatic test_random();
        logic [7:0] ent [18];
        logic [7:0] chk;
        for (int f = 0; f < 16; f++) begin
            for (int k = 0; k < 18; k++)
                ent[k] = ($urandom_range(19, 0) == 0) ? 8'($urandom) : rand_legal();
            chk = ($urandom_range(3, 0) == 0) ? 8'($urandom) : xor_of(ent);
            test_frame($sformatf("random%0d", f), ent, chk, 2, 0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a [18];
        logic [7:0] b [18];
        int h1;
        for (int k = 0; k < 18; k++) begin a[k] = rand_legal(); b[k] = rand_legal(); end
        send_frame(a, xor_of(a), 0, 0);
        h1 = hdr_cyc;
        test_frame("b2b_second", b, xor_of(b), 0, 0);
        checks++;
        if (hdr_cyc - h1 !== 21) begin errors++; $display("FAIL b2b_spacing got %0d want 21", hdr_cyc - h1); end
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_valid = 1'b0;
        cfg_data = 8'h00;
        cfg_abort = 1'b0;
        test_reset();
        test_directed();
        test_idle_abort();
        test_reset_midframe();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_cfg_loader.md
SWITCH_CFG_LOADER -- requirements
Module: switch_cfg_loader

Interface
REQ-001 Parameter HEADER, default 8'hA5, is the frame start byte.
REQ-002 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  is the reset: asynchronous, active-low.
REQ-004 cfg_valid  input  1  SHALL mean cfg_data holds a byte; a byte transfers when cfg_valid && cfg_ready at a rising edge.
REQ-005 cfg_data  input  8  carries the configuration byte stream.
REQ-006 cfg_ready  output  1  SHALL indicate the loader accepts a byte this cycle.
REQ-007 cfg_abort  input  1  is a synchronous request to discard the current frame.
REQ-008 cfg_out  output  108  holds the active switch-matrix config: entry k at bits [6k+5:6k]; k=0..4 top pins 0..4, k=5..9 bottom pins 0..4, k=10..13 left pins 0..3, k=14..17 right pins 0..3.
REQ-009 cfg_done  output  1  pulses for one cycle on a successful commit.
REQ-010 cfg_err  output  1  pulses for one cycle on a rejected frame.
REQ-011 err_code  output  2  SHALL report the reason for the last rejection: 00 none, 01 checksum, 10 illegal entry; it holds until the next done or error.
REQ-012 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-013 Frame format: HEADER, then 18 entry bytes in entry order k=0..17, then 1 checksum byte.
REQ-014 Entry byte format: bits [2:0] sel (0 = high-Z, 1 = top, 2 = right, 3 = bottom, 4 = left), bits [5:3] source index, bits [7:6] SHALL be 0.
REQ-015 An entry SHALL be illegal if any of these hold: bits [7:6] != 0; sel in 5..7; sel in {1,3} with index > 4; sel in {2,4} with index > 3. sel = 0 is legal with any index.
REQ-016 States: IDLE, LOAD, CHK, COMMIT, ERR.
REQ-017 IDLE: cfg_ready = 1; an accepted byte equal to HEADER -> LOAD with entry counter 0, running XOR 0 and illegal flag clear; any other accepted byte SHALL be dropped with no other effect.
REQ-018 LOAD: cfg_ready = 1; each accepted byte SHALL set shadow[counter] = byte[5:0], XOR byte[5:0] into the running checksum, OR its illegality into the illegal flag, and increment the counter; after the byte at counter = 17 -> CHK.
REQ-019 LOAD SHALL NOT treat a HEADER value specially; it is stored as ordinary entry data.
REQ-020 CHK: cfg_ready = 1; on the accepted checksum byte -> ERR with err_code 10 if the illegal flag is set, else ERR with err_code 01 if the byte != {2'b00, running XOR}, else COMMIT. Illegal takes priority over checksum.
REQ-021 COMMIT: cfg_ready = 0 for exactly one cycle; on its exit edge cfg_out <= shadow, cfg_done <= 1 for one cycle, err_code <= 00; then -> IDLE.
REQ-022 ERR: cfg_ready = 0 for exactly one cycle; on its exit edge cfg_err <= 1 for one cycle and err_code is updated; cfg_out SHALL remain unchanged; then -> IDLE.
REQ-023 Latency: cfg_done or cfg_err SHALL be high in the second cycle after the edge that accepts the checksum byte; the minimum frame-to-frame spacing is 21 cycles.
REQ-024 Gaps in cfg_valid SHALL stall the state machine with no timeout; state and counter hold.
REQ-025 cfg_abort in any state SHALL force IDLE on the next edge, discarding the shadow, counter and XOR; it takes priority over a byte transfer in the same cycle, and that byte is not consumed.
REQ-026 cfg_abort SHALL NOT change cfg_out or err_code, and SHALL NOT pulse cfg_done or cfg_err; an abort issued in COMMIT or ERR cancels that cycle's update and pulse.
REQ-027 cfg_out SHALL change only through COMMIT; no partial update is ever visible.

Reset
REQ-028 While rst_n = 0: state = IDLE, cfg_out = 0, shadow = 0, counter = 0, XOR = 0, cfg_done = 0, cfg_err = 0, err_code = 00, busy = 0, cfg_ready = 1 after release.
REQ-029 Reset asserted mid-frame SHALL abandon the frame immediately; the next frame needs a fresh HEADER.

Verification
REQ-030 After reset, send A5, 18×00, 00 -> cfg_done pulse, cfg_out = 108'h0, err_code = 00, cfg_ready low exactly 1 cycle.
REQ-031 Send A5, entry0 = 0A, entry14 = 1C, 16×00, checksum 16 -> cfg_done; cfg_out[5:0] = 0A, cfg_out[89:84] = 1C, all other entries 0.
REQ-032 Same frame with checksum 17 -> cfg_err, err_code = 01, cfg_out unchanged from REQ-031.
REQ-033 Entry3 = 22 (sel 2, index 4) with checksum 22 -> cfg_err, err_code = 10; then entry3 = 2B (sel 3, index 5) -> err_code = 10.
REQ-034 Bytes 00, 13 then A5 in IDLE -> only A5 starts a frame (busy rises after A5); cfg_abort after 9 entries -> IDLE next cycle, no pulses; a following valid frame commits normally.
REQ-035 rst_n low after 10 entries -> cfg_out = 0 and IDLE asynchronously; with cfg_valid stalled for 5 cycles mid-LOAD, the frame still commits with correct data.
